mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter OP_WIDTH, 16, operand width in bits; result width is 2*OP_WIDTH.
REQ-002 Parameter REG_ADDR_W, 3, register-file address width (8 registers).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset:
- clk  input  1  rising-edge clock shared with the register file.
- rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL provide the following ports:
- start  input  1  request to begin an operation.
- op  input  1  0 = unsigned multiply, 1 = unsigned divide.
- operand_a  input  32  multiplicand or dividend; only bits [OP_WIDTH-1:0] are used.
- operand_b  input  32  multiplier or divisor; only bits [OP_WIDTH-1:0] are used.
- dest_reg  input  REG_ADDR_W  destination register of the result.
- busy  output  1  operation in progress (RUN or WB state).
- reg_write  output  1  one-cycle write strobe to the register file.
- write_reg  output  REG_ADDR_W  destination address presented with reg_write.
- write_data  output  32  result presented with reg_write.
- div_by_zero  output  1  sticky flag; set when the last divide had operand_b[15:0] == 0.

Function
REQ-005 The block SHALL implement an FSM with three states:
- IDLE: go to RUN when start == 1; otherwise stay.
- RUN: go to WB when the iteration counter reaches OP_WIDTH-1; otherwise stay.
- WB: go to IDLE unconditionally.
REQ-006 In IDLE with start == 1, the block SHALL latch operand_a[15:0], operand_b[15:0], op and dest_reg, and clear the iteration counter.
REQ-007 A start asserted while busy == 1 SHALL be ignored, with no effect on state, operands or outputs.
REQ-008 In RUN, the block SHALL execute exactly one iteration per cycle for OP_WIDTH (16) cycles, using a 5-bit counter.
REQ-009 Multiply SHALL use an LSB-first shift-add algorithm. Result = a*b, 32 bits, unsigned, with no overflow possible.
REQ-010 Divide SHALL use restoring shift-subtract, MSB-first. Result = {remainder[15:0], quotient[15:0]}.
REQ-011 Divide by zero SHALL be handled as follows:
- Run the full 16 iterations with no early exit.
- Result = {dividend, 16'hFFFF}.
- Set div_by_zero to 1 in the WB cycle.
REQ-012 div_by_zero SHALL clear when the next operation is accepted.
REQ-013 In WB, the block SHALL drive reg_write = 1, write_reg = latched dest_reg and write_data = result, for exactly one cycle.
REQ-014 Outside WB, reg_write SHALL be 0. write_reg and write_data SHALL hold their last values (0 after reset).
REQ-015 Latency: if start is sampled at rising edge N, reg_write SHALL be high during the cycle following edge N+17, i.e. the 18th cycle after acceptance. The register file captures the result at edge N+18.
REQ-016 busy SHALL be 1 from the cycle after acceptance through the WB cycle inclusive. The earliest next start is accepted at edge N+18.
REQ-017 dest_reg == 0 SHALL receive no special treatment; the write is issued unchanged.

Reset
REQ-018 Asserting rst at any time SHALL asynchronously force:
- state to IDLE;
- counter, operand and result registers to 0;
- busy, reg_write and div_by_zero to 0;
- write_reg and write_data to 0.
REQ-019 A reset asserted during RUN or WB SHALL abort the operation and SHALL produce no reg_write pulse.
REQ-020 The first start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-021 Package mdu_pkg SHALL hold:
- the FSM state encoding (IDLE, RUN, WB);
- the op encodings (OP_MULU = 1'b0, OP_DIVU = 1'b1);
- the OP_WIDTH default.
REQ-022 The design SHALL be a single module with no sub-module. Multiply and divide SHALL share one 32-bit accumulator and one 16-bit shift register.

Verification
REQ-023 The bench SHALL cover the following scenarios:
- Multiply: op=0, a=0x0003, b=0x0005, dest=2 -> one reg_write pulse at cycle 18 with write_reg=2, write_data=0x0000000F.
- Multiply max: a=0xFFFF, b=0xFFFF -> write_data=0xFFFE0001.
- Divide: op=1, a=100, b=7 -> write_data=0x0002000E, div_by_zero=0.
- Divide by zero: a=0x1234, b=0 -> write_data=0x1234FFFF and div_by_zero=1. The next accepted start clears div_by_zero.
- Start while busy: a second start at cycle 5 with different operands -> ignored; only the first result is written.
- Reset mid-RUN: assert rst at RUN cycle 8 -> busy=0 immediately, no reg_write. A new start after release completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StWb   = 2'd2
  } state_e;

  localparam logic OP_MULU = 1'b0;
  localparam logic OP_DIVU = 1'b1;

  localparam int unsigned OP_WIDTH_DEFAULT   = 16;
  localparam int unsigned REG_ADDR_W_DEFAULT = 3;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one bit per cycle,
// writing its 2*OP_WIDTH result to a register file through a registered write port.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned OP_WIDTH   = OP_WIDTH_DEFAULT,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic [31:0]           operand_a,
  input  logic [31:0]           operand_b,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  output logic                  busy,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [31:0]           write_data,
  output logic                  div_by_zero
);

  localparam int unsigned ResW = 2 * OP_WIDTH;

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  op_q, op_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  // opnd holds the multiplicand (mul) or divisor (div); sr shifts the other operand.
  logic [OP_WIDTH-1:0]   opnd_q, opnd_d;
  logic [OP_WIDTH-1:0]   sr_q, sr_d;
  logic [ResW-1:0]       acc_q, acc_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [31:0]           write_data_q, write_data_d;
  logic                  div_by_zero_q, div_by_zero_d;

  logic [OP_WIDTH:0]     mul_sum;
  logic [ResW-1:0]       mul_acc;
  logic [OP_WIDTH:0]     div_sh;
  logic                  div_ok;
  logic [OP_WIDTH-1:0]   div_rem;
  logic                  unused_hi;

  assign unused_hi = ^{operand_a[31:OP_WIDTH], operand_b[31:OP_WIDTH]};

  // Multiply step: add multiplicand into the upper half, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc_q[ResW-1:OP_WIDTH]} + (sr_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc = {mul_sum, acc_q[OP_WIDTH-1:1]};

  // Divide step: the partial remainder never exceeds the divisor, so the low bits of the
  // difference are exact whenever the trial subtraction succeeds.
  assign div_sh  = {acc_q[OP_WIDTH-1:0], sr_q[OP_WIDTH-1]};
  assign div_ok  = (div_sh >= {1'b0, opnd_q});
  assign div_rem = div_ok ? (div_sh[OP_WIDTH-1:0] - opnd_q) : div_sh[OP_WIDTH-1:0];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    dest_d        = dest_q;
    opnd_d        = opnd_q;
    sr_d          = sr_q;
    acc_d         = acc_q;
    reg_write_d   = 1'b0;
    write_reg_d   = write_reg_q;
    write_data_d  = write_data_q;
    div_by_zero_d = div_by_zero_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d       = StRun;
          cnt_d         = '0;
          op_d          = op;
          dest_d        = dest_reg;
          opnd_d        = (op == OP_DIVU) ? operand_b[OP_WIDTH-1:0] : operand_a[OP_WIDTH-1:0];
          sr_d          = (op == OP_DIVU) ? operand_a[OP_WIDTH-1:0] : operand_b[OP_WIDTH-1:0];
          acc_d         = '0;
          div_by_zero_d = 1'b0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 5'd1;
        if (op_q == OP_MULU) begin
          acc_d = mul_acc;
          sr_d  = sr_q >> 1;
        end else begin
          acc_d = {{OP_WIDTH{1'b0}}, div_rem};
          sr_d  = {sr_q[OP_WIDTH-2:0], div_ok};
        end
        if (cnt_q == 5'(OP_WIDTH - 1)) begin
          state_d       = StWb;
          div_by_zero_d = (op_q == OP_DIVU) && (opnd_q == '0);
        end
      end
      StWb: begin
        // A zero divisor leaves the dividend in the remainder and all-ones in the quotient.
        state_d      = StIdle;
        reg_write_d  = 1'b1;
        write_reg_d  = dest_q;
        write_data_d = 32'((op_q == OP_DIVU) ? {acc_q[OP_WIDTH-1:0], sr_q} : acc_q);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      op_q          <= OP_MULU;
      dest_q        <= '0;
      opnd_q        <= '0;
      sr_q          <= '0;
      acc_q         <= '0;
      reg_write_q   <= 1'b0;
      write_reg_q   <= '0;
      write_data_q  <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      dest_q        <= dest_d;
      opnd_q        <= opnd_d;
      sr_q          <= sr_d;
      acc_q         <= acc_d;
      reg_write_q   <= reg_write_d;
      write_reg_q   <= write_reg_d;
      write_data_q  <= write_data_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign reg_write   = reg_write_q;
  assign write_reg   = write_reg_q;
  assign write_data  = write_data_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [2:0]  dest_reg;
  logic        busy;
  logic        reg_write;
  logic [2:0]  write_reg;
  logic [31:0] write_data;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(
    .OP_WIDTH  (16),
    .REG_ADDR_W(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .dest_reg   (dest_reg),
    .busy       (busy),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
    int unsigned x;
    int unsigned y;
    logic [15:0] q;
    logic [15:0] r;
    x = a & 32'hFFFF;
    y = b & 32'hFFFF;
    if (!o) return x * y;
    if (y == 0) return {a[15:0], 16'hFFFF};
    q = 16'(x / y);
    r = 16'(x % y);
    return {r, q};
  endfunction

  // Presents a start for one edge, then scrambles the inputs so latching is exercised.
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] d);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b; dest_reg = d;
    @(posedge clk);
    #1;
    start = 1'b0; op = 1'($urandom_range(0, 1)); operand_a = $urandom; operand_b = $urandom;
    dest_reg = 3'($urandom_range(0, 7));
  endtask

  // Observes nmax edges after acceptance; reports first pulse index, pulse count and busy errors.
  task automatic wait_wb(input int nmax, output int first, output int pulses,
                         output logic [31:0] data, output logic [2:0] wr, output logic dz,
                         output int busy_bad);
    first = -1; pulses = 0; busy_bad = 0; data = '0; wr = '0; dz = 1'b0;
    for (int i = 1; i <= nmax; i++) begin
      @(posedge clk);
      #1;
      if (busy !== (i <= 16)) busy_bad++;
      if (reg_write === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        data = write_data; wr = write_reg; dz = div_by_zero;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0; dest_reg = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, reg_write, write_reg, write_data, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b rw=%b wr=%0d wd=%h dz=%b want all zero",
               busy, reg_write, write_reg, write_data, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single(input string name, input logic o, input logic [31:0] a,
                             input logic [31:0] b, input logic [2:0] d);
    int          first, pulses, busy_bad;
    logic [31:0] data, exp;
    logic [2:0]  wr;
    logic        dz, exp_dz;
    exp    = model(o, a, b);
    exp_dz = o && (b[15:0] == 16'h0);
    issue(o, a, b, d);
    wait_wb(24, first, pulses, data, wr, dz, busy_bad);
    n_checks++;
    if (first !== 17 || pulses !== 1) begin
      n_fail++;
      $display("FAIL %s_pulse got first=%0d count=%0d want first=17 count=1", name, first, pulses);
    end
    n_checks++;
    if (data !== exp || wr !== d) begin
      n_fail++;
      $display("FAIL %s_data got %h@%0d want %h@%0d (a=%h b=%h op=%b)",
               name, data, wr, exp, d, a, b, o);
    end
    n_checks++;
    if (dz !== exp_dz) begin
      n_fail++;
      $display("FAIL %s_div_by_zero got %b want %b", name, dz, exp_dz);
    end
    n_checks++;
    if (busy_bad !== 0) begin
      n_fail++;
      $display("FAIL %s_busy got %0d bad cycles want 0", name, busy_bad);
    end
    n_checks++;
    if (write_data !== exp || reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_hold got wd=%h rw=%b want wd=%h rw=0", name, write_data, reg_write, exp);
    end
  endtask

  task automatic test_div_zero_clear();
    n_checks++;
    if (div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_sticky got %b want 1", div_by_zero);
    end
    issue(1'b0, 32'd9, 32'd9, 3'd1);
    n_checks++;
    if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_clear got dz=%b busy=%b want dz=0 busy=1", div_by_zero, busy);
    end
    repeat (20) @(posedge clk);
  endtask

  task automatic test_start_while_busy();
    int          pulses;
    logic [31:0] data;
    logic [2:0]  wr;
    pulses = 0; data = '0; wr = '0;
    issue(1'b0, 32'h0000_1111, 32'h0000_0022, 3'd3);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 5) begin
        start = 1'b1; op = 1'b1; operand_a = 32'd500; operand_b = 32'd3; dest_reg = 3'd6;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (reg_write === 1'b1) begin
        pulses++; data = write_data; wr = write_reg;
      end
    end
    n_checks++;
    if (pulses !== 1 || data !== 32'h0002_4442 || wr !== 3'd3) begin
      n_fail++;
      $display("FAIL busy_start got count=%0d %h@%0d want count=1 00024442@3", pulses, data, wr);
    end
  endtask

  task automatic test_back_to_back();
    int          first, pulses, busy_bad;
    logic [31:0] data;
    logic [2:0]  wr;
    logic        dz;
    issue(1'b1, 32'd1000, 32'd10, 3'd4);
    wait_wb(17, first, pulses, data, wr, dz, busy_bad);
    issue(1'b0, 32'd300, 32'd7, 3'd5);
    n_checks++;
    if (busy !== 1'b1 || first !== 17 || data !== 32'h0000_0064) begin
      n_fail++;
      $display("FAIL back_to_back_accept got busy=%b first=%0d wd=%h want busy=1 17 00000064",
               busy, first, data);
    end
    wait_wb(24, first, pulses, data, wr, dz, busy_bad);
    n_checks++;
    if (first !== 17 || data !== 32'd2100 || wr !== 3'd5) begin
      n_fail++;
      $display("FAIL back_to_back_second got %0d %h@%0d want 17 00000834@5", first, data, wr);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        o;
    for (int k = 0; k < 24; k++) begin
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (k % 6 == 0) b[15:0] = 16'h0;
      if (k % 7 == 3) b[15:0] = 16'h1;
      test_single("random", o, a, b, 3'(k));
    end
  endtask

  task automatic test_reset_mid_run();
    int          first, pulses, busy_bad;
    logic [31:0] data;
    logic [2:0]  wr;
    logic        dz;
    issue(1'b0, 32'h0000_0100, 32'h0000_0100, 3'd7);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, reg_write, write_reg, write_data, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run got busy=%b rw=%b wr=%0d wd=%h dz=%b want all zero",
               busy, reg_write, write_reg, write_data, div_by_zero);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (reg_write !== 1'b0 || busy !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL reset_hold got %0d active cycles want 0", pulses);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b1; op = 1'b0; operand_a = 32'd123; operand_b = 32'd45; dest_reg = 3'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_start got busy=%b want 1", busy);
    end
    wait_wb(24, first, pulses, data, wr, dz, busy_bad);
    n_checks++;
    if (first !== 17 || pulses !== 1 || data !== 32'd5535 || wr !== 3'd2) begin
      n_fail++;
      $display("FAIL reset_recover got first=%0d count=%0d %h@%0d want 17 1 0000159f@2",
               first, pulses, data, wr);
    end
  endtask

  initial begin
    test_reset();
    test_single("mul", 1'b0, 32'h0000_0003, 32'h0000_0005, 3'd2);
    test_single("mul_max", 1'b0, 32'hABCD_FFFF, 32'h1234_FFFF, 3'd0);
    test_single("div", 1'b1, 32'd100, 32'd7, 3'd1);
    test_single("div_zero", 1'b1, 32'h0000_1234, 32'h0000_0000, 3'd6);
    test_div_zero_clear();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
